// File: rtl/gcd_pkg.sv
// GCD controller shared types.
// State encoding and datapath mux select codes.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    SUB_A,
    SUB_B,
    DONE,
    ERR
  } state_t;

  localparam logic SEL_A      = 1'b1;
  localparam logic SEL_B      = 1'b0;
  localparam logic SELIN_SUB  = 1'b1;
  localparam logic SELIN_DATA = 1'b0;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Saturating, clearable subtraction counter.
// at_max flags the iteration limit to the FSM.
module gcd_iter_cnt #(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == MAX_ITER);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gcd_ctrl.sv
// Control FSM for a subtract-and-compare GCD datapath.
// Loads two operands, iterates until equal or the limit is hit.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din_valid,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             lda,
  output logic             ldb,
  output logic             sel1,
  output logic             sel2,
  output logic             selin,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   at_max;

  assign cnt_clr = (state == IDLE) && start;
  assign cnt_inc = (state == SUB_A) || (state == SUB_B);

  gcd_iter_cnt #(
    .CNT_W   (CNT_W),
    .MAX_ITER(MAX_ITER)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (iter_cnt),
    .at_max(at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:   if (start) state <= LOAD_A;
        LOAD_A: if (din_valid) state <= LOAD_B;
        LOAD_B: if (din_valid) state <= CMP;
        CMP: begin
          // equality wins even at the limit
          if (eq)          state <= DONE;
          else if (at_max) state <= ERR;
          else if (lt)     state <= SUB_B;
          else if (gt)     state <= SUB_A;
        end
        SUB_A:  state <= CMP;
        SUB_B:  state <= CMP;
        DONE:   state <= IDLE;
        ERR:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lda       = 1'b0;
    ldb       = 1'b0;
    sel1      = SEL_B;
    sel2      = SEL_B;
    selin     = SELIN_DATA;
    din_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      LOAD_A: begin
        din_ready = 1'b1;
        lda       = din_valid;
      end
      LOAD_B: begin
        din_ready = 1'b1;
        ldb       = din_valid;
      end
      SUB_A: begin
        lda   = 1'b1;
        sel1  = SEL_A;
        sel2  = SEL_B;
        selin = SELIN_SUB;
      end
      SUB_B: begin
        ldb   = 1'b1;
        sel1  = SEL_B;
        sel2  = SEL_A;
        selin = SELIN_SUB;
      end
      DONE: done = 1'b1;
      ERR:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule
